// File: rtl/sequence_slice_ramp_if.sv
// Sequence-word bus into sequence_slice_ramp: word, capture strobe and ramp step size.
interface sequence_slice_ramp_if #(
  parameter int SEQ_WIDTH = 128,
  parameter int DAC_WIDTH = 14
);
  logic [SEQ_WIDTH-1:0] seq_data;
  logic                 seq_valid;
  logic [DAC_WIDTH-1:0] ramp_step;

  modport master (output seq_data, output seq_valid, output ramp_step);
  modport slave  (input  seq_data, input  seq_valid, input  ramp_step);
endinterface

// File: rtl/sequence_slice_ramp.sv
// Sequencer step-word decoder for N_DAC DAC lanes and N_PDM PDM lanes.
// Define SEQ_SLICE_RAMP_DOWN_EN to build the per-DAC linear ramp-to-zero engine.
module sequence_slice_ramp #(
  parameter int N_DAC     = 2,
  parameter int N_PDM     = 4,
  parameter int DAC_WIDTH = 14,
  parameter int PDM_WIDTH = 11,
  parameter int SEQ_WIDTH = 16*(N_DAC+N_PDM)+32
) (
  input  logic                       clk,
  input  logic                       reset,
  sequence_slice_ramp_if.slave       seq,
  output logic [16*N_DAC-1:0]        dac_value,
  output logic [PDM_WIDTH*N_PDM-1:0] pdm_value,
  output logic [N_DAC-1:0]           enable_dac,
  output logic [N_PDM-1:0]           enable_pdm,
  output logic [N_DAC-1:0]           enable_dac_ramp_down,
  output logic [N_DAC-1:0]           ramp_busy,
  output logic [N_DAC-1:0]           ramp_done
);
  localparam int F = 16*(N_DAC+N_PDM);

  logic [SEQ_WIDTH-1:0] word_r;
  logic                 unused_s;

  function automatic logic [15:0] dac_lane(input logic [SEQ_WIDTH-1:0] w, input int i);
    logic signed [DAC_WIDTH-1:0] raw;
    raw = w[16*i +: DAC_WIDTH];
    return 16'(raw);
  endfunction

  // Capture register for the step word; held until the next strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r <= '0;
    end else if (seq.seq_valid) begin
      word_r <= seq.seq_data;
    end else begin
      word_r <= word_r;
    end
  end

  for (genvar j = 0; j < N_PDM; j++) begin : g_pdm
    assign pdm_value[PDM_WIDTH*j +: PDM_WIDTH] = word_r[16*(N_DAC+j) +: PDM_WIDTH];
  end

  assign enable_pdm           = word_r[F+N_DAC +: N_PDM];
  assign enable_dac_ramp_down = word_r[F+16 +: N_DAC];
  assign unused_s             = ^{word_r, seq.ramp_step};

`ifdef SEQ_SLICE_RAMP_DOWN_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } ramp_state_e;

  for (genvar i = 0; i < N_DAC; i++) begin : g_ramp
    ramp_state_e        state_r;
    logic signed [15:0] out_r;
    logic [15:0]        new_val_s;
    logic               new_flag_s;
    logic signed [16:0] cur_s;
    logic signed [16:0] step_s;
    logic signed [16:0] next_s;
    logic               unused_s;

    assign new_val_s  = dac_lane(seq.seq_data, i);
    assign new_flag_s = seq.seq_data[F+16+i];
    assign unused_s   = next_s[16];

    // One decrement toward zero; the result is clamped so it never changes sign.
    always_comb begin
      cur_s  = {out_r[15], out_r};
      step_s = (seq.ramp_step == '0) ? 17'sd1 : signed'(17'(seq.ramp_step));
      next_s = 17'sd0;
      if (cur_s > 17'sd0) begin
        next_s = (cur_s > step_s) ? (cur_s - step_s) : 17'sd0;
      end else if (cur_s < 17'sd0) begin
        next_s = ((-cur_s) > step_s) ? (cur_s + step_s) : 17'sd0;
      end else begin
        next_s = 17'sd0;
      end
    end

    // Lane FSM; out_r follows the decoded value in IDLE and is the ramp register otherwise.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r <= ST_IDLE;
        out_r   <= 16'sd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (seq.seq_valid && new_flag_s) begin
              state_r <= ST_RAMP;
            end else if (seq.seq_valid) begin
              out_r <= new_val_s;
            end else begin
              out_r <= out_r;
            end
          end
          ST_RAMP: begin
            if (seq.seq_valid && !new_flag_s) begin
              state_r <= ST_IDLE;
              out_r   <= new_val_s;
            end else begin
              out_r <= next_s[15:0];
              if (next_s == 17'sd0) begin
                state_r <= ST_HOLD;
              end else begin
                state_r <= ST_RAMP;
              end
            end
          end
          ST_HOLD: begin
            if (seq.seq_valid && !new_flag_s) begin
              state_r <= ST_IDLE;
              out_r   <= new_val_s;
            end else begin
              out_r <= 16'sd0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            out_r   <= 16'sd0;
          end
        endcase
      end
    end

    assign dac_value[16*i +: 16] = out_r;
    assign enable_dac[i]         = (state_r == ST_RAMP) ? 1'b1 : word_r[F+i];
    assign ramp_busy[i]          = (state_r == ST_RAMP);
    assign ramp_done[i]          = (state_r == ST_HOLD);
  end
`else
  for (genvar i = 0; i < N_DAC; i++) begin : g_dac
    assign dac_value[16*i +: 16] = dac_lane(word_r, i);
  end

  assign enable_dac = word_r[F +: N_DAC];
  assign ramp_busy  = '0;
  assign ramp_done  = '0;
`endif

endmodule
